// File: rtl/serial_to_para.sv
// Deserialiser: gathers NUM_WORDS serial words into one big-endian parallel block
// with valid/ready handshakes on both the word input and the block output.
module serial_to_para #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WORD_W-1:0]           in_word,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_block,
    output logic [CNT_W-1:0]            word_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [WORD_W*NUM_WORDS-1:0] block_q, block_d;

    logic accept;
    logic take;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign in_ready  = (state_q == FILL) | out_ready;
    assign out_valid = (state_q == FULL);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    assign out_block = block_q;
    assign word_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        block_d = block_q;

        // cnt_q is 0 whenever FULL, so an accept during a take lands in slot 0.
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (accept && (cnt_q == CNT_W'(k))) begin
                block_d[(NUM_WORDS-1-k)*WORD_W +: WORD_W] = in_word;
            end
        end

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(NUM_WORDS-1)) begin
                        state_d = FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (take) begin
                    state_d = FILL;
                    cnt_d   = accept ? CNT_W'(1) : '0;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end

endmodule

// File: tb/tb_serial_to_para.sv
// Directed and random stimulus for serial_to_para, checked against a queue-based
// model of words received and blocks waiting for the consumer.
module tb_serial_to_para;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned BW = W * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_word;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_block;
    logic [CW-1:0] word_cnt;

    serial_to_para #(.WORD_W(W), .NUM_WORDS(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: words of the partial block in arrival order, plus the held block.
    logic [W-1:0]  part[$];
    logic [BW-1:0] m_blk;
    bit            m_full;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [W-1:0] w,
                       input logic ordy, output bit acc);
        bit take;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_word   = w;
        out_ready = ordy;
        #1;
        chk("in_ready", BW'(in_ready), BW'(!m_full || ordy));
        @(posedge clk);
        acc  = 1'b0;
        if (r) begin
            part.delete();
            m_full = 1'b0;
            m_blk  = '0;
        end else begin
            take = m_full && ordy;
            acc  = v && (!m_full || ordy);
            if (take) m_full = 1'b0;
            if (acc) begin
                part.push_back(w);
                if (part.size() == N) begin
                    m_blk = '0;
                    foreach (part[i]) m_blk = {m_blk[BW-W-1:0], part[i]};
                    part.delete();
                    m_full = 1'b1;
                end
            end
        end
        #1;
        chk("out_valid", BW'(out_valid), BW'(m_full));
        chk("word_cnt", BW'(word_cnt), BW'(part.size()));
        if (m_full) chk("out_block", out_block, m_blk);
    endtask

    initial begin
        bit           acc;
        int           rise1, rise2;
        logic         prev_ov;
        logic [W-1:0] k;

        rst = 1'b1; in_valid = 1'b1; in_word = '0; out_ready = 1'b0;
        m_full = 1'b0; m_blk = '0;

        // 1) reset held two cycles with in_valid high
        cyc(1'b1, 1'b1, 32'h1234_5678, 1'b0, acc);
        cyc(1'b1, 1'b1, 32'h1234_5678, 1'b0, acc);
        chk("rst_block", out_block, '0);
        chk("rst_in_ready", BW'(in_ready), BW'(1'b1));

        // 2) fill 0..15 with out_ready low
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, W'(i), 1'b0, acc);
        chk("fill_msb", BW'(out_block[511:480]), BW'(32'h0));
        chk("fill_lsb", BW'(out_block[31:0]), BW'(32'hF));
        chk("fill_in_ready", BW'(in_ready), BW'(1'b0));

        // 3) hold with ignored input
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, acc);
        chk("hold_lsb", BW'(out_block[31:0]), BW'(32'hF));

        // 4) back-to-back blocks 0x100..0x11F
        rise1 = -1; rise2 = -1; prev_ov = out_valid;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, W'(32'h100 + i), 1'b1, acc);
            if (out_valid && !prev_ov) begin
                if (rise1 < 0) rise1 = i; else rise2 = i;
            end
            prev_ov = out_valid;
        end
        chk("b2b_rise1", BW'(rise1), BW'(15));
        chk("b2b_gap", BW'(rise2 - rise1), BW'(16));
        chk("b2b_msb", BW'(out_block[511:480]), BW'(32'h110));

        // 5) random gaps while filling A5A5A5A5+k
        k = '0;
        for (int i = 0; i < 200 && k < 16; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 32'hA5A5_A5A5 + k,
                1'($urandom_range(0, 1)), acc);
            if (acc) k++;
        end
        chk("gap_done", BW'(k), BW'(16));
        chk("gap_lsb", BW'(out_block[31:0]), BW'(32'hA5A5_A5A5 + 32'd15));

        // 6) mid-block reset after 7 words
        cyc(1'b0, 1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, W'(32'h300 + i), 1'b0, acc);
        cyc(1'b1, 1'b0, '0, 1'b0, acc);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, W'(32'h200 + i), 1'b0, acc);
        chk("mid_rst_msb", BW'(out_block[511:480]), BW'(32'h200));
        chk("mid_rst_lsb", BW'(out_block[31:0]), BW'(32'h20F));

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), W'($urandom),
                1'($urandom_range(0, 2) != 0), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
